simon_3264_core: RTL and testbench

Iterative SIMON 32/64 block cipher core: 32-bit block, 64-bit key, 32 rounds, one round per clock. It expands and stores all 32 round keys, then encrypts or decrypts one block at a time under a newX/loadX/doneX/readData handshake. It sits between a host-side input/output register interface and the key/data sources.

---
 rtl/simon_3264_core_if.sv | 29 ++
 rtl/simon_3264_core.sv | 152 +++++++++++++++
 tb/tb_simon_3264_core.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/simon_3264_core_if.sv
// Host-side handshake and data bus of the SIMON 32/64 core.
// The master is the host; the slave is the cipher core.
interface simon_3264_core_if #(
    parameter int N = 16,
    parameter int M = 4
);
    logic                newData;
    logic                newKey;
    logic                enc_dec;
    logic                readData;
    logic [1:0][N-1:0]   blockIN;
    logic [M-1:0][N-1:0] KEY;
    logic                loadData;
    logic                loadKey;
    logic                doneData;
    logic                doneKey;
    logic [1:0][N-1:0]   outData;
    logic [3:0]          mode;

    modport master (
        output newData, newKey, enc_dec, readData, blockIN, KEY,
        input  loadData, loadKey, doneData, doneKey, outData, mode
    );

    modport slave (
        input  newData, newKey, enc_dec, readData, blockIN, KEY,
        output loadData, loadKey, doneData, doneKey, outData, mode
    );
endinterface

// File: rtl/simon_3264_core.sv
// Iterative SIMON 32/64: expands and stores all round keys, then encrypts or
// decrypts one block per 32 clocks under the newX/loadX/doneX/readData handshake.
module simon_3264_core #(
    parameter int N  = 16,
    parameter int M  = 4,
    parameter int T  = 32,
    parameter int Co = 5
) (
    input logic              clk,
    input logic              nR,
    simon_3264_core_if.slave bus
);
    localparam logic [1:0] KIDLE  = 2'd0;
    localparam logic [1:0] KEXP   = 2'd1;
    localparam logic [1:0] KREADY = 2'd2;
    localparam logic [1:0] DIDLE  = 2'd0;
    localparam logic [1:0] ROUND  = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    // z0 sequence with z0[0] at bit 31, so z0[i] = Z0[31 - i] = Z0[~i].
    localparam logic [31:0]   Z0        = {28'b1111101000100101011000011100, 4'b0000};
    localparam logic [Co-1:0] LASTKEY   = Co'(T - M - 1);
    localparam logic [Co-1:0] LASTROUND = Co'(T - 1);

    logic [1:0]    keyState;
    logic [1:0]    dataState;
    logic          keyArmed;
    logic          dataArmed;
    logic          encMode;
    logic [Co-1:0] keyCnt;
    logic [Co-1:0] roundCnt;
    logic [N-1:0]  x;
    logic [N-1:0]  y;
    logic [N-1:0]  rk [T];

    logic          keyLoad;
    logic          dataLoad;
    logic [N-1:0]  kRot;
    logic [N-1:0]  kTmp;
    logic [N-1:0]  kNext;
    logic [N-1:0]  rkSel;
    logic [N-1:0]  xNext;
    logic [N-1:0]  yNext;

    function automatic logic [N-1:0] simonF(input logic [N-1:0] v);
        return ({v[N-2:0], v[N-1]} & {v[N-9:0], v[N-1:N-8]}) ^ {v[N-3:0], v[N-1:N-2]};
    endfunction

    // A key load wins over a same-cycle data load so rounds never read a half-expanded schedule.
    assign keyLoad  = bus.newKey && keyArmed && (keyState != KEXP) && (dataState != ROUND);
    assign dataLoad = bus.newData && dataArmed && (dataState == DIDLE)
                      && (keyState == KREADY) && !keyLoad;
    assign bus.mode = {keyState, dataState};

    // NOTE: every variable assigned in this block gets a value on every pass, so no latch is inferred.
    always_comb begin
        kRot  = {rk[keyCnt + Co'(3)][2:0], rk[keyCnt + Co'(3)][N-1:3]} ^ rk[keyCnt + Co'(1)];
        kTmp  = kRot ^ {kRot[0], kRot[N-1:1]};
        kNext = ~rk[keyCnt] ^ kTmp ^ N'(Z0[~keyCnt]) ^ N'(3);

        rkSel = rk[encMode ? roundCnt : ~roundCnt];
        if (encMode) begin
            xNext = y ^ simonF(x) ^ rkSel;
            yNext = x;
        end else begin
            xNext = y;
            yNext = x ^ simonF(y) ^ rkSel;
        end
    end

    // NOTE: the round-key store has no reset; keyState/doneKey gate every use, so stale words are never consumed.
    always_ff @(posedge clk) begin
        if (keyLoad) begin
            for (int i = 0; i < M; i++) rk[i] <= bus.KEY[i];
        end else if (keyState == KEXP) begin
            rk[keyCnt + Co'(M)] <= kNext;
        end
    end

    always_ff @(posedge clk or posedge nR) begin
        if (nR) begin
            keyState     <= KIDLE;
            dataState    <= DIDLE;
            keyArmed     <= 1'b1;
            dataArmed    <= 1'b1;
            encMode      <= 1'b0;
            keyCnt       <= '0;
            roundCnt     <= '0;
            x            <= '0;
            y            <= '0;
            bus.loadKey  <= 1'b0;
            bus.loadData <= 1'b0;
            bus.doneKey  <= 1'b0;
            bus.doneData <= 1'b0;
            bus.outData  <= '0;
        end else begin
            bus.loadKey  <= keyLoad;
            bus.loadData <= dataLoad;

            if (keyLoad)           keyArmed <= 1'b0;
            else if (!bus.newKey)  keyArmed <= 1'b1;
            if (dataLoad)          dataArmed <= 1'b0;
            else if (!bus.newData) dataArmed <= 1'b1;

            case (keyState)
                KEXP: begin
                    keyCnt <= keyCnt + 1'b1;
                    if (keyCnt == LASTKEY) begin
                        keyState    <= KREADY;
                        bus.doneKey <= 1'b1;
                    end
                end
                default: begin
                    if (keyLoad) begin
                        keyState    <= KEXP;
                        keyCnt      <= '0;
                        bus.doneKey <= 1'b0;
                    end
                end
            endcase

            case (dataState)
                DIDLE: begin
                    if (dataLoad) begin
                        x         <= bus.blockIN[1];
                        y         <= bus.blockIN[0];
                        encMode   <= bus.enc_dec;
                        roundCnt  <= '0;
                        dataState <= ROUND;
                    end
                end
                ROUND: begin
                    x        <= xNext;
                    y        <= yNext;
                    roundCnt <= roundCnt + 1'b1;
                    if (roundCnt == LASTROUND) begin
                        bus.outData  <= {xNext, yNext};
                        bus.doneData <= 1'b1;
                        dataState    <= DONE;
                    end
                end
                DONE: begin
                    if (bus.readData) begin
                        bus.doneData <= 1'b0;
                        dataState    <= DIDLE;
                    end
                end
                default: dataState <= DIDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_simon_3264_core.sv
// Directed bench for simon_3264_core: known-answer vectors from a table plus
// hand-written handshake, stream and reset sequences.
module tb_simon_3264_core;
    logic clk = 1'b0;
    logic nR  = 1'b0;

    simon_3264_core_if bus ();

    simon_3264_core dut (
        .clk (clk),
        .nR  (nR),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] KAT_PT  = 32'h6565_6877;
    localparam logic [31:0] KAT_CT  = 32'hc69b_e9bb;

    typedef struct {
        string       name;
        logic        encFlag;
        logic [31:0] blk;
        logic [31:0] expOut;
    } vec_t;

    int nCompared   = 0;
    int nMismatched = 0;
    int loadDataCnt = 0;
    int loadKeyCnt  = 0;

    always @(negedge clk) begin
        if (bus.loadData) loadDataCnt <= loadDataCnt + 1;
        if (bus.loadKey)  loadKeyCnt  <= loadKeyCnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Raise newKey, wait for loadKey, then measure the distance to doneKey.
    task automatic loadKeyTask(input string tag, input logic [63:0] key);
        int  base = loadKeyCnt;
        int  lat  = 0;
        logic seen = 1'b0;
        bus.KEY    = key;
        bus.newKey = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (loadKeyCnt > base) begin seen = 1'b1; break; end
        end
        bus.newKey = 1'b0;
        check({tag, "_loadKey_seen"}, 32'(seen), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            lat++;
            if (bus.doneKey) begin seen = 1'b1; break; end
        end
        check({tag, "_doneKey_latency"}, 32'(lat), 32'd28);
    endtask

    task automatic waitLoadData(input string tag, input int base);
        logic seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (loadDataCnt > base) begin seen = 1'b1; break; end
        end
        check({tag, "_loadData_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic startBlock(input string tag, input logic encFlag, input logic [31:0] blk);
        int base = loadDataCnt;
        bus.blockIN = blk;
        bus.enc_dec = encFlag;
        bus.newData = 1'b1;
        waitLoadData(tag, base);
        bus.newData = 1'b0;
    endtask

    task automatic waitDone(output logic [31:0] res, output int lat);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            lat++;
            if (bus.doneData) break;
        end
        res = bus.outData;
    endtask

    task automatic readOut(input string tag);
        bus.readData = 1'b1;
        tick();
        bus.readData = 1'b0;
        check({tag, "_doneData_cleared"}, 32'(bus.doneData), 32'd0);
        check({tag, "_data_idle"}, 32'(bus.mode[1:0]), 32'd0);
    endtask

    task automatic pulseReset();
        nR = 1'b1;
        tick();
        tick();
        nR = 1'b0;
        tick();
    endtask

    initial begin
        vec_t        vecs [4];
        logic [31:0] pts  [5];
        logic [31:0] cts  [5];
        logic [31:0] res;
        int          lat;
        int          base;
        logic        stable;

        vecs[0] = '{"kat_enc",   1'b1, KAT_PT, KAT_CT};
        vecs[1] = '{"kat_dec",   1'b0, KAT_CT, KAT_PT};
        vecs[2] = '{"kat_dec_2", 1'b0, KAT_CT, KAT_PT};
        vecs[3] = '{"kat_enc_2", 1'b1, KAT_PT, KAT_CT};
        pts = '{32'h6565_6877, 32'ha8d5_f7de, 32'h5bc9_2d01, 32'hf2b4_8d45, 32'h567f_11de};

        bus.newData  = 1'b0;
        bus.newKey   = 1'b0;
        bus.enc_dec  = 1'b0;
        bus.readData = 1'b0;
        bus.blockIN  = '0;
        bus.KEY      = '0;

        // Reset state
        #2 nR = 1'b1;
        tick();
        check("reset_flags", 32'({bus.loadData, bus.loadKey, bus.doneData, bus.doneKey}), 32'd0);
        check("reset_outData", bus.outData, 32'd0);
        check("reset_mode", 32'(bus.mode), 32'd0);
        tick();
        nR = 1'b0;
        tick();

        // newKey and newData together: key first, data only after doneKey,
        // newData held across DONE->DIDLE must not reload.
        base = loadDataCnt;
        bus.blockIN = KAT_PT;
        bus.enc_dec = 1'b1;
        bus.newData = 1'b1;
        loadKeyTask("both", KAT_KEY);
        check("both_no_load_before_doneKey", 32'(loadDataCnt - base), 32'd0);
        waitLoadData("both", base);
        waitDone(res, lat);
        check("both_latency", 32'(lat), 32'd32);
        check("both_outData", res, KAT_CT);
        readOut("both");
        for (int i = 0; i < 40; i++) tick();
        check("both_single_load", 32'(loadDataCnt - base), 32'd1);
        check("both_still_idle", 32'(bus.mode), 32'h8);
        bus.newData = 1'b0;
        tick();

        // Table-driven known-answer vectors
        for (int v = 0; v < 4; v++) begin
            startBlock(vecs[v].name, vecs[v].encFlag, vecs[v].blk);
            waitDone(res, lat);
            check({vecs[v].name, "_outData"}, res, vecs[v].expOut);
            check({vecs[v].name, "_latency"}, 32'(lat), 32'd32);
            readOut(vecs[v].name);
        end

        // readData held low: output frozen, pending newData waits
        startBlock("hold", 1'b1, 32'ha8d5_f7de);
        waitDone(res, lat);
        base = loadDataCnt;
        bus.blockIN = KAT_PT;
        bus.enc_dec = 1'b1;
        bus.newData = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.outData !== res || bus.doneData !== 1'b1) stable = 1'b0;
        end
        check("hold_stable", 32'(stable), 32'd1);
        check("hold_no_load", 32'(loadDataCnt - base), 32'd0);
        readOut("hold");
        waitLoadData("hold_pending", base);
        bus.newData = 1'b0;
        waitDone(res, lat);
        check("hold_pending_outData", res, KAT_CT);
        readOut("hold_pending");

        // Stream: encrypt five, reset, decrypt the ciphertexts back
        base = loadDataCnt;
        for (int i = 0; i < 5; i++) begin
            startBlock("stream_enc", 1'b1, pts[i]);
            waitDone(res, lat);
            cts[i] = res;
            readOut("stream_enc");
        end
        check("stream_enc_loads", 32'(loadDataCnt - base), 32'd5);
        check("stream_ct0", cts[0], KAT_CT);
        pulseReset();
        check("stream_rst_doneKey", 32'(bus.doneKey), 32'd0);
        loadKeyTask("stream", KAT_KEY);
        base = loadDataCnt;
        for (int i = 0; i < 5; i++) begin
            startBlock("stream_dec", 1'b0, cts[i]);
            waitDone(res, lat);
            check($sformatf("stream_dec_%0d", i), res, pts[i]);
            readOut("stream_dec");
        end
        check("stream_dec_loads", 32'(loadDataCnt - base), 32'd5);

        // Reset in the middle of a round sequence
        startBlock("midrst", 1'b1, 32'h5bc9_2d01);
        for (int i = 0; i < 10; i++) tick();
        nR = 1'b1;
        #1;
        check("midrst_flags", 32'({bus.loadData, bus.loadKey, bus.doneData, bus.doneKey}), 32'd0);
        check("midrst_outData", bus.outData, 32'd0);
        check("midrst_mode", 32'(bus.mode), 32'd0);
        tick();
        nR = 1'b0;
        tick();
        base = loadDataCnt;
        bus.blockIN = KAT_PT;
        bus.enc_dec = 1'b1;
        bus.newData = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check("midrst_no_load_without_key", 32'(loadDataCnt - base), 32'd0);
        check("midrst_doneKey", 32'(bus.doneKey), 32'd0);
        loadKeyTask("midrst", KAT_KEY);
        waitLoadData("midrst", base);
        bus.newData = 1'b0;
        waitDone(res, lat);
        check("midrst_outData_after_rekey", res, KAT_CT);
        readOut("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
